// File: rtl/fwd_hazard_ctrl.sv
// ============================================================================
// fwd_hazard_ctrl : EX-operand forwarding selects and load-use stall control
// Rev 1.0
// ============================================================================
`default_nettype none

module fwd_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic [1:0]       fwdA_sel_o,
  output logic [1:0]       fwdB_sel_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } rec_t;

  localparam rec_t       BUBBLE   = '0;
  localparam logic [1:0] SEL_RF   = 2'd0;
  localparam logic [1:0] SEL_EXM  = 2'd1;
  localparam logic [1:0] SEL_MWB  = 2'd2;
  localparam logic [1:0] SEL_RET  = 2'd3;

  rec_t             ex_q,  ex_d;
  rec_t             mem_q, mem_d;
  rec_t             wb_q,  wb_d;
  rec_t             ret_q, ret_d;
  logic [1:0]       sel_a_q, sel_a_d;
  logic [1:0]       sel_b_q, sel_b_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             hazard;
  logic             load_ex;

  function automatic logic is_live(input rec_t r);
    return r.valid && r.regwrite && (r.rd != '0);
  endfunction

  // Newest producer wins: EX is one instruction older than ID, then MEM, then WB.
  function automatic logic [1:0] pick_sel(input logic [REG_W-1:0] src,
                                          input rec_t ex, input rec_t mem,
                                          input rec_t wb);
    logic [1:0] s;
    s = SEL_RF;
    if (src != '0) begin
      if (is_live(ex) && ex.rd == src)        s = SEL_EXM;
      else if (is_live(mem) && mem.rd == src) s = SEL_MWB;
      else if (is_live(wb) && wb.rd == src)   s = SEL_RET;
    end
    return s;
  endfunction

  always_comb begin
    hazard  = id_valid_i && is_live(ex_q) && ex_q.memread &&
              ((ex_q.rd == id_rs_i) || (ex_q.rd == id_rt_i));
    stall_o = hazard && !flush_i;
    load_ex = id_valid_i && !stall_o && !flush_i;

    ret_d = wb_q;
    wb_d  = mem_q;
    mem_d = ex_q;
    ex_d  = BUBBLE;
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (load_ex) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = id_rd_i;
      ex_d.regwrite = id_regwrite_i;
      ex_d.memread  = id_memread_i;
      sel_a_d = pick_sel(id_rs_i, ex_q, mem_q, wb_q);
      sel_b_d = pick_sel(id_rt_i, ex_q, mem_q, wb_q);
    end

    cnt_d = cnt_q;
    if (stall_o && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_q    <= BUBBLE;
      ret_q   <= BUBBLE;
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      ret_q   <= ret_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwdA_sel_o  = sel_a_q;
  assign fwdB_sel_o  = sel_b_q;
  assign stall_cnt_o = cnt_q;

  // RET is tracked so the pipeline depth matches the CPU's hold register.
  logic unused_ret;
  assign unused_ret = ^ret_q;

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
// ============================================================================
// tb_fwd_hazard_ctrl : vector-table bench for fwd_hazard_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fwd_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        id_valid_i = 1'b0;
  logic [4:0]  id_rs_i = '0;
  logic [4:0]  id_rt_i = '0;
  logic [4:0]  id_rd_i = '0;
  logic        id_regwrite_i = 1'b0;
  logic        id_memread_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [1:0]  fwdA_sel_o;
  logic [1:0]  fwdB_sel_o;
  logic        stall_o;
  logic [15:0] stall_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  fwd_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .flush_i(flush_i),
    .fwdA_sel_o(fwdA_sel_o), .fwdB_sel_o(fwdB_sel_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt, rd;
    logic       rw, mr, fl;
    logic [1:0] ea, eb;
    logic       es;
    logic [15:0] ec;
  } vec_t;

  localparam int NV = 32;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic v, input int rs, input int rt, input int rd,
                              input logic rw, input logic mr, input logic fl,
                              input int ea, input int eb, input logic es, input int ec);
    vec_t t;
    t.v = v; t.rs = 5'(rs); t.rt = 5'(rt); t.rd = 5'(rd);
    t.rw = rw; t.mr = mr; t.fl = fl;
    t.ea = 2'(ea); t.eb = 2'(eb); t.es = es; t.ec = 16'(ec);
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input int rs, input int rt, input int rd,
                       input logic rw, input logic mr, input logic fl);
    id_valid_i = v; id_rs_i = 5'(rs); id_rt_i = 5'(rt); id_rd_i = 5'(rd);
    id_regwrite_i = rw; id_memread_i = mr; flush_i = fl;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // v rs rt rd rw mr fl | selA selB stall cnt  (selects belong to the previous row)
    tbl[0]  = mk(1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0);   // add r3
    tbl[1]  = mk(1, 3, 3, 6, 1, 0, 0, 0, 0, 0, 0);   // sub uses r3
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);   // sub in EX: 1/1
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);   // producer r5
    tbl[5]  = mk(1, 8, 9, 10, 1, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 5, 11, 12, 1, 0, 0, 0, 0, 0, 0); // consumer r5
    tbl[7]  = mk(1, 0, 0, 13, 1, 0, 0, 2, 0, 0, 0);  // producer r13
    tbl[8]  = mk(1, 0, 0, 14, 1, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 15, 1, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 13, 0, 16, 1, 0, 0, 0, 0, 0, 0); // consumer r13
    tbl[11] = mk(1, 0, 0, 17, 1, 0, 0, 3, 0, 0, 0);  // producer r17
    tbl[12] = mk(1, 0, 0, 18, 1, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 19, 1, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 0, 0, 20, 1, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 17, 0, 21, 1, 0, 0, 0, 0, 0, 0); // three in between
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[17] = mk(1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0);   // load r7
    tbl[18] = mk(1, 0, 7, 22, 1, 0, 0, 0, 0, 1, 0);  // load-use stall
    tbl[19] = mk(1, 0, 7, 22, 1, 0, 0, 0, 0, 0, 1);  // held consumer
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1);
    tbl[21] = mk(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1);   // r4 older
    tbl[22] = mk(1, 0, 0, 23, 1, 0, 0, 0, 0, 0, 1);
    tbl[23] = mk(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1);   // r4 newer
    tbl[24] = mk(1, 4, 0, 24, 1, 0, 0, 0, 0, 0, 1);
    tbl[25] = mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1);   // writes r0
    tbl[26] = mk(1, 0, 4, 25, 1, 0, 0, 0, 0, 0, 1);
    tbl[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1);
    tbl[28] = mk(1, 0, 0, 26, 1, 1, 0, 0, 0, 0, 1);  // load r26
    tbl[29] = mk(1, 26, 26, 27, 1, 0, 1, 0, 0, 0, 1);// hazard + flush
    tbl[30] = mk(1, 27, 0, 28, 1, 0, 0, 0, 0, 0, 1); // r27 was squashed
    tbl[31] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset state
    step();
    #3;
    check("rst_selA", fwdA_sel_o, 0);
    check("rst_selB", fwdB_sel_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_cnt", stall_cnt_o, 0);
    step();
    rst_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].fl);
      #4;
      check($sformatf("v%0d_selA", i), fwdA_sel_o, tbl[i].ea);
      check($sformatf("v%0d_selB", i), fwdB_sel_o, tbl[i].eb);
      check($sformatf("v%0d_stall", i), stall_o, tbl[i].es);
      check($sformatf("v%0d_cnt", i), stall_cnt_o, tbl[i].ec);
      step();
    end

    // Asynchronous reset mid-stream with live records and an active stall
    drive(1, 0, 0, 30, 1, 0, 0);
    step();
    drive(1, 30, 0, 29, 1, 1, 0);
    step();
    drive(1, 29, 0, 31, 1, 0, 0);
    #2;
    check("pre_rst_selA", fwdA_sel_o, 1);
    check("pre_rst_stall", stall_o, 1);
    check("pre_rst_cnt", stall_cnt_o, 1);
    rst_i = 1'b0;
    #1;
    check("async_selA", fwdA_sel_o, 0);
    check("async_selB", fwdB_sel_o, 0);
    check("async_stall", stall_o, 0);
    check("async_cnt", stall_cnt_o, 0);
    step();
    rst_i = 1'b1;
    drive(1, 29, 30, 31, 1, 0, 0);
    #2;
    check("post_rst_stall", stall_o, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("post_rst_selA", fwdA_sel_o, 0);
    check("post_rst_selB", fwdB_sel_o, 0);
    check("post_rst_cnt", stall_cnt_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
